// File: rtl/mcu_bus_port.sv
// MCU parallel bus front end: strobe synchroniser, RX FIFO and turnaround-managed TX path.
// Optional glitch filter on the strobe edge detector: define MCU_BUS_GLITCH_FILTER_EN.
module mcu_bus_port #(
    parameter int DATA_WIDTH        = 8,
    parameter int SYNC_STAGES       = 2,
    parameter int FIFO_DEPTH        = 4,
    parameter int TURNAROUND_CYCLES = 2
) (
    input  logic                  system_clock,
    input  logic                  system_reset_n,
    input  logic                  bus_clock,
    input  logic [DATA_WIDTH-1:0] bus_data_in,
    input  logic                  bus_command_data_in,
    output logic [DATA_WIDTH-1:0] bus_data_out,
    output logic                  bus_command_data_out,
    output logic                  bus_direction,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_is_command,
    output logic                  rx_overflow,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_is_command
);

    localparam int ADDR_W = $clog2(FIFO_DEPTH);
    localparam int PTR_W  = ADDR_W + 1;
    localparam int CNT_W  = (TURNAROUND_CYCLES > 1) ? $clog2(TURNAROUND_CYCLES) : 1;
    localparam logic [CNT_W-1:0] TURN_LAST = CNT_W'(TURNAROUND_CYCLES - 1);
`ifdef MCU_BUS_GLITCH_FILTER_EN
    localparam int HIST_W = 2;
`else
    localparam int HIST_W = 1;
`endif

    typedef enum logic [1:0] {
        ST_RX       = 2'd0,
        ST_TURN_OUT = 2'd1,
        ST_TX       = 2'd2,
        ST_TURN_IN  = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] sync_r;
    logic [HIST_W-1:0]      hist_r;
    logic                   sync_out_s;
    logic                   rise_s;
    logic [DATA_WIDTH:0]    bus_word_r;

    logic [DATA_WIDTH:0]    fifo_mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr_r;
    logic [PTR_W-1:0]       rd_ptr_r;
    logic                   fifo_empty_s;
    logic                   fifo_full_s;
    logic                   push_req_s;
    logic                   push_s;
    logic                   pop_s;
    logic                   rx_overflow_r;

    state_t                 state_r;
    state_t                 state_nxt_s;
    logic [CNT_W-1:0]       cnt_r;
    logic [CNT_W-1:0]       cnt_nxt_s;
    logic                   tx_ready_s;
    logic                   tx_load_s;
    logic                   bus_dir_r;
    logic [DATA_WIDTH:0]    bus_word_out_r;

    assign sync_out_s = sync_r[SYNC_STAGES-1];
`ifdef MCU_BUS_GLITCH_FILTER_EN
    // Edge only after two consecutive high samples preceded by a low (pattern 011).
    assign rise_s = ~hist_r[1] & hist_r[0] & sync_out_s;
`else
    assign rise_s = sync_out_s & ~hist_r[0];
`endif

    // Strobe synchroniser, edge history and single registration of the MCU word
    always_ff @(posedge system_clock or negedge system_reset_n) begin
        if (!system_reset_n) begin
            sync_r     <= {SYNC_STAGES{1'b1}};
            hist_r     <= {HIST_W{1'b1}};
            bus_word_r <= {(DATA_WIDTH+1){1'b0}};
        end else begin
            sync_r     <= {sync_r[SYNC_STAGES-2:0], bus_clock};
`ifdef MCU_BUS_GLITCH_FILTER_EN
            hist_r     <= {hist_r[0], sync_out_s};
`else
            hist_r     <= sync_out_s;
`endif
            bus_word_r <= {bus_command_data_in, bus_data_in};
        end
    end

    assign fifo_empty_s = (wr_ptr_r == rd_ptr_r);
    assign fifo_full_s  = (wr_ptr_r[ADDR_W] != rd_ptr_r[ADDR_W]) &&
                          (wr_ptr_r[ADDR_W-1:0] == rd_ptr_r[ADDR_W-1:0]);
    assign pop_s        = ~fifo_empty_s & rx_ready;
    assign push_req_s   = rise_s & (state_r == ST_RX);
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign push_s       = push_req_s & (~fifo_full_s | pop_s);

    // RX FIFO storage, pointers and overflow pulse
    always_ff @(posedge system_clock or negedge system_reset_n) begin
        if (!system_reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem_r[i] <= {(DATA_WIDTH+1){1'b0}};
            end
            wr_ptr_r      <= {PTR_W{1'b0}};
            rd_ptr_r      <= {PTR_W{1'b0}};
            rx_overflow_r <= 1'b0;
        end else begin
            if (push_s) begin
                fifo_mem_r[wr_ptr_r[ADDR_W-1:0]] <= bus_word_r;
                wr_ptr_r <= wr_ptr_r + 1'b1;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end
            rx_overflow_r <= push_req_s & fifo_full_s & ~pop_s;
        end
    end

    // Direction FSM next state and TX handshake
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        tx_ready_s  = 1'b0;
        tx_load_s   = 1'b0;
        case (state_r)
            ST_RX: begin
                if (tx_valid && !rise_s) begin
                    tx_ready_s  = 1'b1;
                    tx_load_s   = 1'b1;
                    state_nxt_s = ST_TURN_OUT;
                    cnt_nxt_s   = {CNT_W{1'b0}};
                end else begin
                    state_nxt_s = ST_RX;
                end
            end
            ST_TURN_OUT: begin
                if (cnt_r == TURN_LAST) begin
                    state_nxt_s = ST_TX;
                    cnt_nxt_s   = {CNT_W{1'b0}};
                end else begin
                    cnt_nxt_s   = cnt_r + 1'b1;
                end
            end
            ST_TX: begin
                if (rise_s) begin
                    if (tx_valid) begin
                        tx_ready_s = 1'b1;
                        tx_load_s  = 1'b1;
                    end else begin
                        state_nxt_s = ST_TURN_IN;
                        cnt_nxt_s   = {CNT_W{1'b0}};
                    end
                end else begin
                    state_nxt_s = ST_TX;
                end
            end
            ST_TURN_IN: begin
                if (cnt_r == TURN_LAST) begin
                    state_nxt_s = ST_RX;
                    cnt_nxt_s   = {CNT_W{1'b0}};
                end else begin
                    cnt_nxt_s   = cnt_r + 1'b1;
                end
            end
            default: begin
                state_nxt_s = ST_RX;
                cnt_nxt_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // FSM state and turnaround counter
    always_ff @(posedge system_clock or negedge system_reset_n) begin
        if (!system_reset_n) begin
            state_r <= ST_RX;
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Registered bus-side outputs; the word holds after the bus turns back to input
    always_ff @(posedge system_clock or negedge system_reset_n) begin
        if (!system_reset_n) begin
            bus_dir_r      <= 1'b0;
            bus_word_out_r <= {(DATA_WIDTH+1){1'b0}};
        end else begin
            bus_dir_r <= (state_nxt_s == ST_TURN_OUT) || (state_nxt_s == ST_TX);
            if (tx_load_s) begin
                bus_word_out_r <= {tx_is_command, tx_data};
            end
        end
    end

    assign bus_direction        = bus_dir_r;
    assign bus_data_out         = bus_word_out_r[DATA_WIDTH-1:0];
    assign bus_command_data_out = bus_word_out_r[DATA_WIDTH];
    assign rx_valid             = ~fifo_empty_s;
    assign rx_data              = fifo_mem_r[rd_ptr_r[ADDR_W-1:0]][DATA_WIDTH-1:0];
    assign rx_is_command        = fifo_mem_r[rd_ptr_r[ADDR_W-1:0]][DATA_WIDTH];
    assign rx_overflow          = rx_overflow_r;
    assign tx_ready             = tx_ready_s;

endmodule

// File: tb/tb_mcu_bus_port.sv
// Scoreboard bench for mcu_bus_port: queue-based FIFO model, MCU strobe model and TX word checks.
module tb_mcu_bus_port;
    localparam int DW    = 8;
    localparam int SYNC  = 2;
    localparam int DEPTH = 4;
    localparam int TURN  = 2;
`ifdef MCU_BUS_GLITCH_FILTER_EN
    localparam int FILT = 1;
`else
    localparam int FILT = 0;
`endif
    // Edges after the first edge that sees the strobe high until the word is pushed.
    localparam int LAT = SYNC + FILT;

    logic          system_clock = 1'b0;
    logic          system_reset_n;
    logic          bus_clock;
    logic [DW-1:0] bus_data_in;
    logic          bus_command_data_in;
    logic [DW-1:0] bus_data_out;
    logic          bus_command_data_out;
    logic          bus_direction;
    logic          rx_valid;
    logic          rx_ready;
    logic [DW-1:0] rx_data;
    logic          rx_is_command;
    logic          rx_overflow;
    logic          tx_valid;
    logic          tx_ready;
    logic [DW-1:0] tx_data;
    logic          tx_is_command;

    mcu_bus_port #(
        .DATA_WIDTH(DW), .SYNC_STAGES(SYNC), .FIFO_DEPTH(DEPTH), .TURNAROUND_CYCLES(TURN)
    ) dut (
        .system_clock(system_clock), .system_reset_n(system_reset_n), .bus_clock(bus_clock),
        .bus_data_in(bus_data_in), .bus_command_data_in(bus_command_data_in),
        .bus_data_out(bus_data_out), .bus_command_data_out(bus_command_data_out),
        .bus_direction(bus_direction), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .rx_data(rx_data), .rx_is_command(rx_is_command), .rx_overflow(rx_overflow),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data), .tx_is_command(tx_is_command)
    );

    always #5 system_clock = ~system_clock;

    int          errors = 0;
    int          checks = 0;
    logic [DW:0] rx_q[$];
    logic [DW:0] tx_q[$];
    bit          mon_en = 1'b0;
    bit          tx_mode = 1'b0;
    bit          exp_ovf = 1'b0;
    bit          rx_rand = 1'b0;
    int          acc_count = 0;
    int          ovf_seen = 0;
    logic        dir_pre, dir_post, tr_pre, tr_post;
    logic [DW:0] word_post;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge system_clock);
        #1;
        if (rx_rand) rx_ready = 1'($urandom_range(0, 1));
    endtask

    // RX scoreboard: head valid, overflow pulse and popped words against the queue model.
    always @(negedge system_clock) begin
        logic [DW:0] head;
        if (mon_en && system_reset_n) begin
            check("rx_valid", 32'(rx_valid), 32'(rx_q.size() != 0));
            check("rx_overflow", 32'(rx_overflow), 32'(exp_ovf));
            if (rx_overflow) ovf_seen++;
            if (rx_q.size() != 0 && rx_ready) begin
                head = rx_q.pop_front();
                check("rx_word", 32'({rx_is_command, rx_data}), 32'(head));
            end
        end
    end

    // TX acceptance monitor: every handshake enqueues the word the MCU must later see.
    always @(negedge system_clock) begin
        if (system_reset_n && tx_valid && tx_ready) begin
            tx_q.push_back({tx_is_command, tx_data});
            acc_count++;
        end
    end

    // MCU side: a strobe in output mode consumes the word currently on the bus.
    always @(posedge bus_clock) begin
        logic [DW:0] head;
        if (tx_mode) begin
            check("tx_bus_dir", 32'(bus_direction), 32'd1);
            if (tx_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL tx_consume: bus strobed with no accepted word pending at %0t", $time);
            end else begin
                head = tx_q.pop_front();
                check("tx_bus_word", 32'({bus_command_data_out, bus_data_out}), 32'(head));
            end
        end
    end

    // One MCU write strobe; txc=1 drops tx_valid at the rise, txc=2 offers txd during the rise.
    task automatic mcu_write(input logic [DW-1:0] d, input logic f, input int hi, input int lo,
                             input int txc, input logic [DW-1:0] txd, input bit pp);
        automatic bit glitch = (FILT != 0) && (hi < 2);
        automatic int last = ((hi > LAT + 1) ? hi : LAT + 1) + lo;
        bus_data_in = d;
        bus_command_data_in = f;
        tick();
        bus_clock = 1'b1;
        for (int k = 1; k <= last; k++) begin
            tick();
            exp_ovf = 1'b0;
            if (k == hi) bus_clock = 1'b0;
            if (pp) rx_ready = (k == LAT);
            if (k == LAT) begin
                dir_pre = bus_direction;
                if (txc == 2) begin
                    tx_valid = 1'b1;
                    tx_data = txd;
                    tx_is_command = 1'b0;
                    #1;
                    tr_pre = tx_ready;
                end
            end
            if (k == LAT + 1) begin
                dir_post = bus_direction;
                word_post = {bus_command_data_out, bus_data_out};
                tr_post = tx_ready;
                if (txc == 1) tx_valid = 1'b0;
                if (!tx_mode && !glitch) begin
                    if (rx_q.size() < DEPTH) rx_q.push_back({f, d});
                    else exp_ovf = 1'b1;
                end
            end
            if (k == LAT + 2 && txc == 2) tx_valid = 1'b0;
        end
    endtask

    task automatic tx_offer(input logic [DW-1:0] d, input logic f);
        automatic bit ok = 1'b0;
        tx_data = d;
        tx_is_command = f;
        tx_valid = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge system_clock);
            ok = tx_ready;
            tick();
        end
        tx_valid = 1'b0;
        check("tx_accept", 32'(ok), 32'd1);
    endtask

    task automatic drain();
        rx_rand = 1'b0;
        rx_ready = 1'b1;
        repeat (DEPTH + 4) tick();
        rx_ready = 1'b0;
        check("drain_rx_valid", 32'(rx_valid), 32'd0);
    endtask

    initial begin
        int a0, o0;
        system_reset_n = 1'b0;
        bus_clock = 1'b1;
        bus_data_in = '0;
        bus_command_data_in = 1'b0;
        rx_ready = 1'b0;
        tx_valid = 1'b0;
        tx_data = '0;
        tx_is_command = 1'b0;
        repeat (3) @(posedge system_clock);
        @(negedge system_clock);
        check("rst_dir", 32'(bus_direction), 32'd0);
        check("rst_bus_word", 32'({bus_command_data_out, bus_data_out}), 32'd0);
        check("rst_rx_valid", 32'(rx_valid), 32'd0);
        check("rst_overflow", 32'(rx_overflow), 32'd0);
        check("rst_tx_ready", 32'(tx_ready), 32'd0);

        // Strobe held high through reset release: no edge, FIFO stays empty.
        tick();
        system_reset_n = 1'b1;
        mon_en = 1'b1;
        repeat (10) tick();
        check("no_push_after_rst", 32'(rx_valid), 32'd0);
        bus_clock = 1'b0;
        repeat (3) tick();

        // Single command word and first-word-fall-through latency, then pop.
        mcu_write(8'hA5, 1'b1, 3, 3, 0, 8'h00, 1'b0);
        check("a5_head", 32'({rx_is_command, rx_data}), 32'h1A5);
        drain();

        // Five writes into a four-entry FIFO: one overflow, first four kept in order.
        o0 = ovf_seen;
        for (int i = 1; i <= 5; i++) mcu_write(DW'(i), 1'b0, 2, 2, 0, 8'h00, 1'b0);
        check("ovf_pulses", 32'(ovf_seen - o0), 32'd1);
        drain();

        // Full FIFO with a pop on the push cycle: word accepted, no overflow.
        o0 = ovf_seen;
        for (int i = 0; i < 4; i++) mcu_write(8'h40 + DW'(i), 1'b1, 2, 2, 0, 8'h00, 1'b0);
        mcu_write(8'h4F, 1'b0, 2, 2, 0, 8'h00, 1'b1);
        check("full_pop_push_ovf", 32'(ovf_seen - o0), 32'd0);
        drain();

        // Short pulse: rejected with the glitch filter, pushed without it.
        mcu_write(8'h66, 1'b0, 1, 3, 0, 8'h00, 1'b0);
        mcu_write(8'hC3, 1'b1, 3, 3, 0, 8'h00, 1'b0);
        drain();

        // Random writes with a randomly stalling consumer.
        rx_rand = 1'b1;
        for (int i = 0; i < 20; i++)
            mcu_write(DW'($urandom), 1'($urandom_range(0, 1)), $urandom_range(2, 4),
                      $urandom_range(1, 3), 0, 8'h00, 1'b0);
        drain();

        // Single TX word, consumed by one strobe, then back to input mode.
        a0 = acc_count;
        tx_offer(8'h3C, 1'b0);
        tx_mode = 1'b1;
        @(negedge system_clock);
        check("tx_dir_out", 32'(bus_direction), 32'd1);
        check("tx_word_3c", 32'({bus_command_data_out, bus_data_out}), 32'h03C);
        repeat (TURN) tick();
        mcu_write(8'h00, 1'b0, 3, 3, 0, 8'h00, 1'b0);
        tx_mode = 1'b0;
        check("tx1_dir_pre", 32'(dir_pre), 32'd1);
        check("tx1_dir_post", 32'(dir_post), 32'd0);
        check("tx1_dir_end", 32'(bus_direction), 32'd0);
        check("tx1_word_held", 32'({bus_command_data_out, bus_data_out}), 32'h03C);
        check("tx1_accepts", 32'(acc_count - a0), 32'd1);

        // Back-to-back words: second accepted on the first strobe's rise.
        a0 = acc_count;
        tx_offer(8'h11, 1'b1);
        tx_mode = 1'b1;
        tx_valid = 1'b1;
        tx_data = 8'h22;
        tx_is_command = 1'b0;
        repeat (TURN + 1) tick();
        check("b2b_no_early_accept", 32'(acc_count - a0), 32'd1);
        mcu_write(8'h00, 1'b0, 3, 3, 1, 8'h00, 1'b0);
        check("b2b_accepts", 32'(acc_count - a0), 32'd2);
        check("b2b_dir_post", 32'(dir_post), 32'd1);
        check("b2b_word_22", 32'(word_post), 32'h022);
        mcu_write(8'h00, 1'b0, 3, 3, 0, 8'h00, 1'b0);
        tx_mode = 1'b0;
        check("b2b_dir_end", 32'(dir_post), 32'd0);
        check("b2b_tx_q_empty", 32'(tx_q.size()), 32'd0);

        // Rise and tx_valid together in input mode: push wins, tx retried next cycle.
        a0 = acc_count;
        mcu_write(8'h5A, 1'b0, 3, 3, 2, 8'h77, 1'b0);
        check("race_tx_refused", 32'(tr_pre), 32'd0);
        check("race_tx_retry", 32'(tr_post), 32'd1);
        check("race_accepts", 32'(acc_count - a0), 32'd1);
        tx_mode = 1'b1;
        tick();
        mcu_write(8'h00, 1'b0, 3, 3, 0, 8'h00, 1'b0);
        tx_mode = 1'b0;
        drain();

        // Reset in output mode with a non-empty FIFO.
        mcu_write(8'hE1, 1'b0, 2, 2, 0, 8'h00, 1'b0);
        mcu_write(8'hE2, 1'b1, 2, 2, 0, 8'h00, 1'b0);
        tx_offer(8'h99, 1'b1);
        tx_mode = 1'b1;
        repeat (TURN + 1) tick();
        check("pre_rst_dir", 32'(bus_direction), 32'd1);
        #2;
        system_reset_n = 1'b0;
        rx_q.delete();
        tx_q.delete();
        tx_mode = 1'b0;
        #1;
        check("async_rst_dir", 32'(bus_direction), 32'd0);
        check("async_rst_rx_valid", 32'(rx_valid), 32'd0);
        check("async_rst_bus_word", 32'({bus_command_data_out, bus_data_out}), 32'd0);
        repeat (2) tick();
        system_reset_n = 1'b1;
        repeat (4) tick();
        check("post_rst_rx_valid", 32'(rx_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time budget exceeded");
        $fatal(1);
    end
endmodule
